// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data memory responder and its lane-alignment
// helper.
//   - SIZE_* : access size encodings (funct3[1:0] of RV64 loads/stores)
//   - state_t: responder FSM states
//   - align_mask()  : low address bits that must be zero for a given size
//   - size_byte_en(): byte-lane enable pattern of a size, before lane shift
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Any address bit set under this mask means the access is misaligned.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SIZE_BYTE: mask = 3'b000;
            SIZE_HALF: mask = 3'b001;
            SIZE_WORD: mask = 3'b011;
            default:   mask = 3'b111;
        endcase
        return mask;
    endfunction

    // Byte lanes touched by an access of the given size at offset 0.
    function automatic logic [7:0] size_byte_en(input logic [1:0] size);
        logic [7:0] be;
        case (size)
            SIZE_BYTE: be = 8'b0000_0001;
            SIZE_HALF: be = 8'b0000_0011;
            SIZE_WORD: be = 8'b0000_1111;
            default:   be = 8'b1111_1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane handling for one 64-bit storage word.
//   i_word        : current contents of the addressed storage word
//   i_offset      : byte offset of the access within the word (address[2:0])
//   i_size        : access size (SIZE_BYTE..SIZE_DOUBLE)
//   i_unsigned    : zero-extend loads when 1 (ignored for double)
//   i_write_data  : store data, right-aligned
//   o_load_data   : addressed lanes shifted down and sign/zero extended
//   o_merged_word : i_word with the addressed lanes replaced by store data
// Callers only use the outputs for aligned accesses, so the lanes never wrap
// past the top of the word.
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [63:0] i_word,
    input  logic [2:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [63:0] i_write_data,
    output logic [63:0] o_load_data,
    output logic [63:0] o_merged_word
);

    logic [5:0]  w_shift;
    logic [63:0] w_lane;
    logic [63:0] w_wdata_shifted;
    logic [7:0]  w_byte_en;
    logic [63:0] w_bit_mask;

    assign w_shift         = {i_offset, 3'b000};
    assign w_lane          = i_word >> w_shift;
    assign w_wdata_shifted = i_write_data << w_shift;
    assign w_byte_en       = size_byte_en(i_size) << i_offset;

    // Load: addressed lane now sits at bit 0; extend from its top bit.
    always_comb begin
        o_load_data = w_lane;
        case (i_size)
            SIZE_BYTE: o_load_data = i_unsigned ? {56'd0, w_lane[7:0]}
                                                : {{56{w_lane[7]}}, w_lane[7:0]};
            SIZE_HALF: o_load_data = i_unsigned ? {48'd0, w_lane[15:0]}
                                                : {{48{w_lane[15]}}, w_lane[15:0]};
            SIZE_WORD: o_load_data = i_unsigned ? {32'd0, w_lane[31:0]}
                                                : {{32{w_lane[31]}}, w_lane[31:0]};
            default:   o_load_data = w_lane;
        endcase
    end

    // Store: expand byte enables to a bit mask and merge lane by lane.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_bit_mask[gi*8 +: 8] = {8{w_byte_en[gi]}};
        end
    endgenerate

    assign o_merged_word = (i_word & ~w_bit_mask) | (w_wdata_shifted & w_bit_mask);

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Responder side of the core's load/store interface. Accepts one request at a
// time, spends exactly LATENCY cycles in WAIT, commits the access on the last
// WAIT edge, then holds the response in RESP until the core takes it.
// Storage is a byte-addressed little-endian array of 64-bit words that is not
// cleared by reset.
//
// Parameters
//   ADDR_WIDTH : byte-address bits decoded (capacity 2^ADDR_WIDTH bytes)
//   LATENCY    : WAIT cycles before commit, 1..15
// Ports
//   clock, reset                  : clock, synchronous active-high reset
//   req_valid / req_ready         : request handshake
//   req_write, req_address,
//   req_size, req_unsigned,
//   req_write_data                : request payload, sampled on acceptance
//   resp_valid / resp_ready       : response handshake
//   resp_read_data, resp_error    : response payload, stable while in RESP
//
// Timing: if the handshake is seen in cycle 0, cycles 1..LATENCY are WAIT and
// resp_valid is high from cycle LATENCY+1. With an immediate resp_ready the
// next request can be taken LATENCY+2 cycles after the previous one.
// -----------------------------------------------------------------------------
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_address,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_read_data,
    output logic        resp_error
);

    localparam int IDX_W = ADDR_WIDTH - 3;
    localparam int WORDS = 1 << IDX_W;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    // FSM
    state_t r_state;
    state_t w_state_next;

    // Latched request
    logic             r_write;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [2:0]       r_offset;
    logic [IDX_W-1:0] r_index;
    logic [63:0]      r_wdata;
    logic             r_error;

    // Latency counter and response registers
    logic [3:0]  r_count;
    logic [63:0] r_resp_data;
    logic        r_resp_error;

    // Storage with registered read
    logic [63:0] r_mem [0:WORDS-1];
    logic [63:0] r_rd_word;

    logic        w_accept;
    logic        w_commit;
    logic        w_resp_done;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [63:0] w_load_data;
    logic [63:0] w_merged_word;

    assign w_accept       = req_valid & req_ready;
    assign w_commit       = (r_state == WAIT) && (r_count == 4'd0);
    assign w_resp_done    = resp_valid & resp_ready;
    assign w_misaligned   = |(req_address[2:0] & align_mask(req_size));
    assign w_out_of_range = |req_address[63:ADDR_WIDTH];

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_next = WAIT;
            WAIT:    if (w_commit)    w_state_next = RESP;
            RESP:    if (w_resp_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (r_state == IDLE);
        resp_valid     = (r_state == RESP);
        resp_read_data = r_resp_data;
        resp_error     = r_resp_error;
    end

    // ----------------------------------------------------------- datapath ---
    // The request payload is only meaningful on acceptance, so it is latched
    // then and the live inputs are ignored for the rest of the transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count      <= 4'd0;
            r_resp_data  <= 64'd0;
            r_resp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_offset   <= req_address[2:0];
                r_index    <= req_address[ADDR_WIDTH-1:3];
                r_wdata    <= req_write_data;
                r_error    <= w_misaligned | w_out_of_range;
                r_count    <= COUNT_LOAD;
            end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end

            if (w_commit) begin
                r_resp_error <= r_error;
                r_resp_data  <= (r_error || r_write) ? 64'd0 : w_load_data;
            end
        end
    end

    // ------------------------------------------------------------ storage ---
    // The word is read on acceptance so it is ready by the first WAIT cycle,
    // which covers LATENCY = 1. Only one request is in flight, so no write can
    // land between this read and the commit that uses it. A reset on the
    // commit edge abandons the store.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_rd_word <= r_mem[req_address[ADDR_WIDTH-1:3]];
        end
        if (w_commit && r_write && !r_error && !reset) begin
            r_mem[r_index] <= w_merged_word;
        end
    end

    mem_lane_align u_lane_align (
        .i_word        (r_rd_word),
        .i_offset      (r_offset),
        .i_size        (r_size),
        .i_unsigned    (r_unsigned),
        .i_write_data  (r_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Randomised and directed requests against a byte-array reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

    localparam int ADDR_WIDTH = 10;
    localparam int LATENCY    = 2;
    localparam int MEM_BYTES  = 1 << ADDR_WIDTH;
    localparam int TIMEOUT    = 50;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_address;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_read_data;
    logic        resp_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mdl [0:MEM_BYTES-1];
    logic [63:0] last_data;
    logic        last_err;

    always #5 clock = ~clock;

    data_memory_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_write_data (req_write_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_read_data (resp_read_data),
        .resp_error     (resp_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic model_err(input logic [63:0] a, input logic [1:0] s);
        return (a >= 64'(MEM_BYTES)) || ((a % 64'(nbytes(s))) != 64'd0);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] s,
                                               input logic u);
        logic [63:0] v;
        int n;
        int base;
        v    = 64'd0;
        n    = nbytes(s);
        base = int'(a[ADDR_WIDTH-1:0]);
        for (int i = 0; i < n; i++) v = v | (64'(mdl[base + i]) << (8 * i));
        if (!u && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        int base;
        base = int'(a[ADDR_WIDTH-1:0]);
        for (int i = 0; i < nbytes(s); i++) mdl[base + i] = d[8*i +: 8];
    endtask

    // ------------------------------------------------------------ stimulus
    task automatic drive_req(input logic w, input logic [63:0] a, input logic [1:0] s,
                             input logic u, input logic [63:0] d);
        req_valid      = 1'b1;
        req_write      = w;
        req_address    = a;
        req_size       = s;
        req_unsigned   = u;
        req_write_data = d;
    endtask

    // Waits for req_ready, lets the handshake edge pass, then scrambles the
    // request inputs. Returns at the falling edge of cycle 1 after acceptance.
    task automatic accept_req(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid      = 1'b0;
        req_write      = 1'($urandom);
        req_address    = {$urandom, $urandom};
        req_size       = 2'($urandom);
        req_unsigned   = 1'($urandom);
        req_write_data = {$urandom, $urandom};
    endtask

    // Called in cycle 1 after acceptance; response expected in cycle LATENCY+1.
    task automatic finish_req(input string tag, input logic [63:0] exp_data,
                              input logic exp_err, input int hold);
        int n;
        n = 1;
        while (!resp_valid && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(LATENCY + 1));
        last_data = resp_read_data;
        last_err  = resp_error;
        check({tag, "_data"}, resp_read_data, exp_data);
        check({tag, "_err"}, 64'(resp_error), 64'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "_hold_data"}, resp_read_data, exp_data);
            check({tag, "_hold_err"}, 64'(resp_error), 64'(exp_err));
            check({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check({tag, "_drop"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic do_txn(input string tag, input logic w, input logic [63:0] a,
                          input logic [1:0] s, input logic u, input logic [63:0] d,
                          input int hold);
        logic        err;
        logic [63:0] exp;
        err = model_err(a, s);
        exp = (err || w) ? 64'd0 : model_load(a, s, u);
        drive_req(w, a, s, u, d);
        accept_req(tag);
        finish_req(tag, exp, err, hold);
        if (w && !err) model_store(a, s, d);
    endtask

    // -------------------------------------------------------------- main
    initial begin
        logic        w;
        logic [63:0] a;
        logic [1:0]  s;

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_address    = 64'd0;
        req_size       = 2'd0;
        req_unsigned   = 1'b0;
        req_write_data = 64'd0;
        resp_ready     = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_state_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_read_data, 64'd0);
        check("rst_resp_err", 64'(resp_error), 64'd0);

        // Give storage known contents so every load has a model value.
        for (int i = 0; i < MEM_BYTES / 8; i++)
            do_txn("init", 1'b1, 64'(i * 8), SZ_D, 1'b0, {$urandom, $urandom}, 0);

        // Reset in the middle of WAIT: the store must not land.
        drive_req(1'b1, 64'h10, SZ_B, 1'b0, 64'hAA);
        accept_req("rst_wait");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rstw_ready", 64'(req_ready), 64'd1);
        check("rstw_valid", 64'(resp_valid), 64'd0);
        check("rstw_data", resp_read_data, 64'd0);
        do_txn("rstw_load", 1'b0, 64'h10, SZ_D, 1'b0, 64'd0, 0);

        // Double store/load
        do_txn("dbl_st", 1'b1, 64'h08, SZ_D, 1'b0, 64'h0123456789ABCDEF, 0);
        do_txn("dbl_ld", 1'b0, 64'h08, SZ_D, 1'b1, 64'd0, 0);
        check("dbl_value", last_data, 64'h0123456789ABCDEF);

        // Extension
        do_txn("ext_sb", 1'b1, 64'h21, SZ_B, 1'b0, 64'h80, 0);
        do_txn("ext_lb", 1'b0, 64'h21, SZ_B, 1'b0, 64'd0, 0);
        check("ext_lb_value", last_data, 64'hFFFFFFFFFFFFFF80);
        do_txn("ext_lbu", 1'b0, 64'h21, SZ_B, 1'b1, 64'd0, 0);
        check("ext_lbu_value", last_data, 64'h80);
        do_txn("ext_sh", 1'b1, 64'h22, SZ_H, 1'b0, 64'h8001, 0);
        do_txn("ext_lh", 1'b0, 64'h22, SZ_H, 1'b0, 64'd0, 0);
        check("ext_lh_value", last_data, 64'hFFFFFFFFFFFF8001);
        do_txn("ext_lwu", 1'b0, 64'h20, SZ_W, 1'b1, 64'd0, 0);

        // Lane preservation
        do_txn("lane_sd", 1'b1, 64'h30, SZ_D, 1'b0, 64'h1111111111111111, 0);
        do_txn("lane_sb", 1'b1, 64'h33, SZ_B, 1'b0, 64'hFF, 0);
        do_txn("lane_ld", 1'b0, 64'h30, SZ_D, 1'b0, 64'd0, 0);
        check("lane_value", last_data, 64'h11111111FF111111);

        // Errors
        do_txn("err_misal", 1'b0, 64'h06, SZ_W, 1'b0, 64'd0, 0);
        check("err_misal_flag", 64'(last_err), 64'd1);
        do_txn("err_range", 1'b1, 64'h400, SZ_B, 1'b0, 64'hFF, 0);
        check("err_range_flag", 64'(last_err), 64'd1);
        do_txn("err_after", 1'b0, 64'h00, SZ_D, 1'b0, 64'd0, 0);

        // Backpressure with a second request waiting.
        drive_req(1'b0, 64'h08, SZ_D, 1'b0, 64'd0);
        accept_req("bp_a");
        drive_req(1'b0, 64'h30, SZ_D, 1'b0, 64'd0);
        finish_req("bp_a", model_load(64'h08, SZ_D, 1'b0), 1'b0, 5);
        check("bp_idle_ready", 64'(req_ready), 64'd1);
        accept_req("bp_b");
        finish_req("bp_b", model_load(64'h30, SZ_D, 1'b0), 1'b0, 0);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            w = 1'($urandom);
            s = 2'($urandom);
            a = 64'($urandom_range(0, MEM_BYTES - 1));
            if (($urandom % 4) != 0) a = a & ~64'(nbytes(s) - 1);
            if (($urandom % 8) == 0) a[ADDR_WIDTH + ($urandom % (64 - ADDR_WIDTH))] = 1'b1;
            do_txn("rand", w, a, s, 1'($urandom), {$urandom, $urandom}, int'($urandom % 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
